seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WORD_W, default 16: width of each parallel input word.
REQ-002 Parameter PAT_MAX, default 8: maximum pattern length in bits.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, asynchronous and active-high.
REQ-006 cfg_pattern  in  PAT_MAX: target pattern; bit [cfg_len-1] is the first bit in time, bit 0 the last.
REQ-007 cfg_len  in  $clog2(PAT_MAX+1): pattern length; legal range is 2..PAT_MAX.
REQ-008 word_valid  in  1: the source offers a word.
REQ-009 word_data  in  WORD_W: the offered word; it is scanned MSB first.
REQ-010 word_last  in  1: the offered word is the final word of the frame.
REQ-011 word_ready  out  1: the block can accept a word.
REQ-012 match_pulse  out  1: one-cycle pulse for each detected match.
REQ-013 match_count  out  CNT_W: number of matches in the current or most recent frame.
REQ-014 busy  out  1: a frame is in progress.
REQ-015 done  out  1: one-cycle pulse at the end of a frame.
REQ-016 err  out  1: illegal cfg_len was sampled at frame start.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE; word_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, a word SHALL be accepted when word_valid && word_ready; the block SHALL capture word_data and word_last and enter SHIFT on the next cycle.
REQ-019 The first accepted word of a frame SHALL latch cfg_pattern and cfg_len, set busy=1, and clear match_count and err; these latched values SHALL stay fixed until the frame ends.
REQ-020 In SHIFT, the block SHALL present exactly one bit per cycle, MSB first, for WORD_W cycles, using a bit-index counter.
REQ-021 After the last bit, the FSM SHALL go to DONE if the captured word_last=1, otherwise it SHALL return to IDLE.
REQ-022 Matcher history SHALL persist across words within a frame, so that patterns spanning a word boundary are detected.
REQ-023 A match SHALL be flagged when the most recent cfg_len bits, including the current bit, equal cfg_pattern[cfg_len-1:0] and the fill count is at least cfg_len-1.
REQ-024 match_pulse SHALL be registered: it asserts in the cycle after the matching bit is presented.
REQ-025 match_count SHALL increment on each match and saturate at 2^CNT_W-1, with no wrap-around.
REQ-026 DONE SHALL last one cycle with done=1; the last-bit match SHALL be counted before done asserts.
REQ-027 In DONE, the block SHALL clear busy, clear matcher history and return to IDLE; match_count SHALL hold until the next frame starts.
REQ-028 If the latched cfg_len is illegal, err SHALL assert and remain set until the next frame start; the frame SHALL still be consumed and terminated with done, with no matches counted.
REQ-029 cfg_* changes in mid-frame SHALL have no effect.

Reset
REQ-030 While rst=1: FSM=IDLE, word_ready=1, busy=0, done=0, match_pulse=0, err=0, match_count=0, history and fill cleared.
REQ-031 A reset in mid-frame SHALL abandon the frame with no done pulse; the block SHALL accept a new word in the first cycle after release.

Configuration
REQ-032 Macro SEQ_SCAN_OVERLAP_EN defined: after a match the fill count SHALL be kept, so overlapping matches are counted.
REQ-033 Macro SEQ_SCAN_OVERLAP_EN undefined: a match SHALL reset the fill count to 0, so the next match needs cfg_len fresh bits.

Structure
REQ-034 A shared package seq_scan_pkg SHALL hold the FSM state enum and the default values of WORD_W, PAT_MAX and CNT_W.
REQ-035 The bit-level Mealy comparator SHALL be a sub-module, seq_matcher, with ports: bit in, enable, clear, latched pattern/len, and match output; the controller SHALL own the FSM, the handshake and the counter.

Verification
REQ-036 Pattern 1011, len 4, single word 0xB0B0 with last=1 -> two match_pulses, match_count=2, done one cycle after the final match slot.
REQ-037 Pattern 101, len 3, word 0x5555 with last=1 -> match_count=7 with OVERLAP_EN defined; match_count=4 with it undefined (matches at bits 3, 7, 11, 15).
REQ-038 Pattern 1011, len 4, word 0x0001 (last=0) then word 0x6000 (last=1) -> exactly one match, on bit 2 of the second word; match_count=1.
REQ-039 Pattern 11, len 2, OVERLAP_EN defined, 18 words of 0xFFFF, last on the 18th -> match_count saturates at 255, no wrap.
REQ-040 cfg_len=1 at frame start -> err=1, match_count=0, done still pulses; the next frame with len 4 clears err.
REQ-041 rst asserted at bit 7 of SHIFT -> busy=0, match_count=0, no done pulse, word_ready=1 the cycle after release.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern scanner: parameter defaults,
// controller FSM encoding and the cfg_len legality check.
// Optional feature macro: SEQ_SCAN_OVERLAP_EN (overlapping matches).
package seq_scan_pkg;

  localparam int WORD_W_DEF  = 16;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A pattern needs at least two bits and must fit the history register.
  function automatic logic len_legal(input int len, input int pat_max);
    return (len >= 2) && (len <= pat_max);
  endfunction

endpackage

// File: rtl/seq_scan_if.sv
// Word handshake between a word source (master) and the scanner (slave).
// Optional feature macro: SEQ_SCAN_OVERLAP_EN (not used in this file).
interface seq_scan_if
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_last;
  logic              word_ready;

  modport master (output word_valid, output word_data, output word_last, input  word_ready);
  modport slave  (input  word_valid, input  word_data, input  word_last, output word_ready);
endinterface

// File: rtl/seq_matcher.sv
// Bit-serial Mealy pattern comparator. Keeps a shift history of past bits and
// a fill count of how many valid history bits exist; match is combinational
// on the current bit so the controller can register it.
// Optional feature macro: SEQ_SCAN_OVERLAP_EN -- when defined the fill count
// survives a match so overlapping occurrences are reported; otherwise a match
// restarts the fill count and the next match needs len fresh bits.
module seq_matcher
  import seq_scan_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               enable,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_MAX-1:0] window_s;
  logic [PAT_MAX-1:0] mask_s;
  logic               match_s;

  // Most recent bits with the current one in position 0, and the mask of the
  // low len bits that take part in the comparison.
  always_comb begin
    window_s = {hist_q[PAT_MAX-2:0], bit_in};
    mask_s   = {PAT_MAX{1'b0}};
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (i < int'(len));
    end
  end

  assign match_s = enable && !clear &&
                   (fill_q >= (len - LEN_W'(1))) &&
                   ((window_s & mask_s) == (pattern & mask_s));
  assign match   = match_s;

  // History and fill-count update; fill saturates at PAT_MAX.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = {PAT_MAX{1'b0}};
      fill_d = {LEN_W{1'b0}};
    end else if (enable) begin
      hist_d = window_s;
      if (match_s && !OVERLAP) begin
        fill_d = {LEN_W{1'b0}};
      end else if (fill_q < LEN_W'(PAT_MAX)) begin
        fill_d = fill_q + LEN_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // History and fill-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= {PAT_MAX{1'b0}};
      fill_q <= {LEN_W{1'b0}};
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame scanner controller: accepts words over a valid/ready handshake,
// serialises each word MSB first, feeds seq_matcher and counts matches per
// frame with a saturating counter. Configuration is latched on the first
// word of a frame; an illegal length flags err and suppresses matching.
// Optional feature macro: SEQ_SCAN_OVERLAP_EN (handled inside seq_matcher).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  seq_scan_if.slave          bus,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = $clog2(WORD_W);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic accept_s;
  logic frame_start_s;
  logic last_bit_s;
  logic match_s;
  logic m_enable_s;
  logic m_clear_s;

  assign accept_s      = bus.word_valid && ready_q;
  assign frame_start_s = accept_s && !busy_q;
  assign last_bit_s    = (idx_q == IDX_W'(WORD_W - 1));
  // Matching is suppressed for the whole frame when the latched length is bad.
  assign m_enable_s    = (state_q == ST_SHIFT) && !err_q;
  assign m_clear_s     = (state_q == ST_DONE) || frame_start_s;

  seq_matcher #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (word_q[WORD_W-1]),
    .enable  (m_enable_s),
    .clear   (m_clear_s),
    .pattern (pat_q),
    .len     (len_q),
    .match   (match_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for a word, SHIFT runs WORD_W bit slots,
  // DONE is a single cycle at the end of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_SHIFT;
        else          state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          if (last_q) state_d = ST_DONE;
          else        state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered from these.
  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    busy_d  = busy_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          word_d = bus.word_data;
          last_d = bus.word_last;
          idx_d  = {IDX_W{1'b0}};
          if (!busy_q) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            busy_d  = 1'b1;
            count_d = {CNT_W{1'b0}};
            err_d   = !len_legal(int'(cfg_len), PAT_MAX);
          end else begin
            pat_d = pat_q;
            len_d = len_q;
          end
        end else begin
          word_d = word_q;
        end
      end
      ST_SHIFT: begin
        word_d = {word_q[WORD_W-2:0], 1'b0};
        if (last_bit_s) idx_d = {IDX_W{1'b0}};
        else            idx_d = idx_q + IDX_W'(1);
        if (match_s && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
        else                                      count_d = count_q;
      end
      ST_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
    pulse_d = match_s;
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= {WORD_W{1'b0}};
      last_q  <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      pat_q   <= {PAT_MAX{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.word_ready = ready_q;
  assign match_pulse    = pulse_q;
  assign match_count    = count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl (default parameters).
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  localparam int WW = 16;
  localparam int PM = 8;
  localparam int CW = 8;
  localparam int LW = $clog2(PM + 1);

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam int EXP_5555 = 7;
  localparam int SAT_WORDS = 18;
`else
  localparam int EXP_5555 = 4;
  localparam int SAT_WORDS = 33;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PM-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          match_pulse, busy, done, err;
  logic [CW-1:0] match_count;

  seq_scan_if #(.WORD_W(WW)) bus();

  seq_scan_ctrl #(.WORD_W(WW), .PAT_MAX(PM), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pulse_log[$];
  int dones = 0;
  int done_cyc = -1;
  always @(negedge clk) begin
    if (match_pulse === 1'b1) pulse_log.push_back(cyc);
    if (done === 1'b1) begin
      dones = dones + 1;
      done_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one word starting #1 after a rising edge; returns the accept edge count.
  task automatic send_word(input logic [WW-1:0] d, input logic l, output int acc);
    int n;
    n = 0;
    while (bus.word_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    bus.word_valid = 1'b1;
    bus.word_data  = d;
    bus.word_last  = l;
    @(posedge clk); #1;
    acc = cyc;
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
  endtask

  // Wait for the next done pulse (bounded), then move to #1 after the next edge.
  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (dones == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dones == base) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int a, a2, pb, db;
    bus.word_valid = 1'b0;
    bus.word_data  = 16'h0000;
    bus.word_last  = 1'b0;
    cfg_pattern    = 8'h0B;
    cfg_len        = 4'd4;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.word_ready), 32'd1);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_pulse", 32'(match_pulse),    32'd0);
    check("rst_err",   32'(err),            32'd0);
    check("rst_count", 32'(match_count),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1011 over 0xB0B0, with a mid-frame cfg change that must be ignored
    pb = pulse_log.size(); db = dones;
    send_word(16'hB0B0, 1'b1, a);
    cfg_pattern = 8'h00;
    cfg_len     = 4'd1;
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(db, 40);
    check("t1_npulse",   32'(pulse_log.size() - pb), 32'd2);
    if (pulse_log.size() - pb >= 2) begin
      check("t1_pulse0", 32'(pulse_log[pb]),     32'(a + 4));
      check("t1_pulse1", 32'(pulse_log[pb + 1]), 32'(a + 12));
    end
    check("t1_done_cyc", 32'(done_cyc),      32'(a + 16));
    check("t1_ndone",    32'(dones - db),    32'd1);
    check("t1_count",    32'(match_count),   32'd2);
    check("t1_err",      32'(err),           32'd0);
    check("t1_busy_end", 32'(busy),          32'd0);
    check("t1_ready",    32'(bus.word_ready), 32'd1);

    // 101 over 0x5555
    cfg_pattern = 8'h05; cfg_len = 4'd3;
    db = dones;
    send_word(16'h5555, 1'b1, a);
    wait_done(db, 40);
    check("t2_count", 32'(match_count), 32'(EXP_5555));

    // 1011 spanning a word boundary
    cfg_pattern = 8'h0B; cfg_len = 4'd4;
    pb = pulse_log.size(); db = dones;
    send_word(16'h0001, 1'b0, a);
    repeat (WW) @(posedge clk);
    #1;
    check("t3_ready_mid", 32'(bus.word_ready), 32'd1);
    check("t3_busy_mid",  32'(busy),           32'd1);
    send_word(16'h6000, 1'b1, a2);
    wait_done(db, 40);
    check("t3_count",  32'(match_count),             32'd1);
    check("t3_npulse", 32'(pulse_log.size() - pb),   32'd1);
    if (pulse_log.size() - pb >= 1) check("t3_pulse_cyc", 32'(pulse_log[pb]), 32'(a2 + 3));

    // Saturation with pattern 11 over all-ones words
    cfg_pattern = 8'h03; cfg_len = 4'd2;
    db = dones;
    for (int i = 0; i < SAT_WORDS; i++) begin
      send_word(16'hFFFF, (i == SAT_WORDS - 1), a);
    end
    wait_done(db, 60);
    check("t4_sat", 32'(match_count), 32'd255);

    // Illegal length: err, no matches, done still pulses
    cfg_pattern = 8'h01; cfg_len = 4'd1;
    pb = pulse_log.size(); db = dones;
    send_word(16'hFFFF, 1'b1, a);
    check("t5_err", 32'(err), 32'd1);
    wait_done(db, 40);
    check("t5_ndone",  32'(dones - db),            32'd1);
    check("t5_count",  32'(match_count),           32'd0);
    check("t5_npulse", 32'(pulse_log.size() - pb), 32'd0);
    check("t5_err_hold", 32'(err),                 32'd1);

    // Next legal frame clears err
    cfg_pattern = 8'h0B; cfg_len = 4'd4;
    db = dones;
    send_word(16'hB0B0, 1'b1, a);
    check("t6_err_clr", 32'(err), 32'd0);
    wait_done(db, 40);
    check("t6_count", 32'(match_count), 32'd2);

    // Reset at bit 7 of SHIFT
    cfg_pattern = 8'h03; cfg_len = 4'd2;
    db = dones;
    send_word(16'hFFFF, 1'b0, a);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t7_busy",  32'(busy),           32'd0);
    check("t7_count", 32'(match_count),    32'd0);
    check("t7_ready", 32'(bus.word_ready), 32'd1);
    check("t7_pulse", 32'(match_pulse),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t7_ready_rel", 32'(bus.word_ready), 32'd1);
    cfg_pattern = 8'h0B; cfg_len = 4'd4;
    a2 = cyc;
    send_word(16'hB0B0, 1'b1, a);
    check("t7_acc_first", 32'(a),          32'(a2 + 1));
    check("t7_nodone",    32'(dones - db), 32'd0);
    wait_done(db, 40);
    check("t7_count_new", 32'(match_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
